// File: rtl/l1_msi_cache_2way.sv
// L1 data cache: 2-way set-associative, 1-byte lines, MSI, LRU.
// Shared-bus req/ack for misses/upgrades/writebacks; snoop port.
module l1_msi_cache_2way #(
  parameter int SETS   = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] fetched_data,
  output logic              core_stall,
  output logic              core_done,
  output logic              bus_req,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_op,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_flush,
  output logic [DATA_W-1:0] snoop_data
);

  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - IW;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_M = 2'd2;

  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_RDX = 2'b10;
  localparam logic [1:0] OP_WB  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_UPG,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              way_q, way_d;

  logic [TW-1:0]     tag_q [2][SETS];
  logic [TW-1:0]     tag_d [2][SETS];
  logic [DATA_W-1:0] dat_q [2][SETS];
  logic [DATA_W-1:0] dat_d [2][SETS];
  logic [1:0]        st_q  [2][SETS];
  logic [1:0]        st_d  [2][SETS];
  logic [SETS-1:0]   lru_q, lru_d;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0]    hit;
  logic          hit_way;
  logic          vict;

  logic [IW-1:0] sidx;
  logic [TW-1:0] stag;
  logic [1:0]    shit;
  logic          sway;
  logic          sany;
  logic [1:0]    sst;

  assign idx = addr_q[IW-1:0];
  assign tag = addr_q[ADDR_W-1:IW];

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      hit[w] = (st_q[w][idx] != ST_I) &&
               (tag_q[w][idx] == tag);
    end
  end

  assign hit_way = !hit[0];

  // Prefer the lowest invalid way; only fall back to LRU when full.
  assign vict = (st_q[0][idx] == ST_I) ? 1'b0 :
                (st_q[1][idx] == ST_I) ? 1'b1 :
                lru_q[idx];

  assign sidx = snoop_addr[IW-1:0];
  assign stag = snoop_addr[ADDR_W-1:IW];

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      shit[w] = (st_q[w][sidx] != ST_I) &&
                (tag_q[w][sidx] == stag);
    end
  end

  assign sway = !shit[0];
  assign sany = |shit;
  assign sst  = st_q[sway][sidx];

  assign snoop_flush = snoop_valid && sany &&
                       (sst == ST_M) &&
                       ((snoop_op == OP_RD) ||
                        (snoop_op == OP_RDX));
  assign snoop_data  = snoop_flush ? dat_q[sway][sidx]
                                   : '0;

  assign core_stall = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    way_d        = way_q;
    tag_d        = tag_q;
    dat_d        = dat_q;
    st_d         = st_q;
    lru_d        = lru_q;
    bus_req      = 1'b0;
    bus_op       = 2'b00;
    bus_addr     = '0;
    bus_wdata    = '0;
    core_done    = 1'b0;
    fetched_data = '0;

    // Snoop first so a same-cycle local update overrides it.
    if (snoop_valid && sany) begin
      if (snoop_op == OP_RD && sst == ST_M) begin
        st_d[sway][sidx] = ST_S;
      end else if (snoop_op == OP_RDX) begin
        st_d[sway][sidx] = ST_I;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          addr_d  = address;
          wdata_d = write_data;
          wr_d    = write;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (|hit) begin
          way_d = hit_way;
          if (!wr_q) begin
            state_d = S_RESP;
          end else if (st_q[hit_way][idx] == ST_M) begin
            dat_d[hit_way][idx] = wdata_q;
            state_d = S_RESP;
          end else begin
            state_d = S_UPG;
          end
        end else begin
          way_d   = vict;
          state_d = (st_q[vict][idx] == ST_M) ? S_WB
                                              : S_FILL;
        end
      end
      S_WB: begin
        bus_req   = 1'b1;
        bus_op    = OP_WB;
        bus_addr  = {tag_q[way_q][idx], idx};
        bus_wdata = dat_q[way_q][idx];
        if (bus_ack) begin
          st_d[way_q][idx] = ST_I;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        bus_req  = 1'b1;
        bus_op   = wr_q ? OP_RDX : OP_RD;
        bus_addr = addr_q;
        if (bus_ack) begin
          tag_d[way_q][idx] = tag;
          dat_d[way_q][idx] = wr_q ? wdata_q : bus_rdata;
          st_d[way_q][idx]  = wr_q ? ST_M : ST_S;
          state_d = S_RESP;
        end
      end
      S_UPG: begin
        bus_req  = 1'b1;
        bus_op   = OP_RDX;
        bus_addr = addr_q;
        if (bus_ack) begin
          if (st_q[way_q][idx] == ST_S) begin
            dat_d[way_q][idx] = wdata_q;
            st_d[way_q][idx]  = ST_M;
            state_d = S_RESP;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_RESP: begin
        core_done    = 1'b1;
        fetched_data = dat_q[way_q][idx];
        lru_d[idx]   = ~way_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      way_q   <= 1'b0;
      lru_q   <= '0;
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s] <= '0;
          dat_q[w][s] <= '0;
          st_q[w][s]  <= ST_I;
        end
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      way_q   <= way_d;
      lru_q   <= lru_d;
      tag_q   <= tag_d;
      dat_q   <= dat_d;
      st_q    <= st_d;
    end
  end

endmodule
